mem_mmio_bus: RTL and testbench

//   Sits between the single-cycle CPU data bus (mem_addr/mem_we/mem_din/mem_dout) and the data memory plus PDU I/O.

---
 rtl/mmio_pkg.sv | 23 ++
 rtl/mmio_in_chan.sv | 47 ++++
 rtl/mem_mmio_bus.sv | 129 ++++++++++++
 tb/tb_mem_mmio_bus.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
//  mmio_pkg : MMIO window layout shared by the CPU bus bridge
//  Revision : 1.0
// ============================================================================
package mmio_pkg;

   localparam logic [31:0] MMIO_BASE_DEF   = 32'h0000_7f00;
   localparam int          MMIO_WIN_BYTES  = 32;

   localparam logic [4:0]  OFF_OUT_STAT    = 5'h00;
   localparam logic [4:0]  OFF_OUT_DATA    = 5'h04;
   localparam logic [4:0]  OFF_IN_STAT     = 5'h08;
   localparam logic [4:0]  OFF_IN_DATA     = 5'h0C;
   localparam logic [4:0]  OFF_CYCLES      = 5'h10;
   localparam logic [4:0]  OFF_LED         = 5'h14;

   localparam int          OUT_STAT_RDY_BIT = 0;
   localparam int          IN_STAT_VLD_BIT  = 0;
   localparam int          IN_STAT_OVR_BIT  = 1;

endpackage
`default_nettype wire

// File: rtl/mmio_in_chan.sv
`default_nettype none
// ============================================================================
//  mmio_in_chan : PDU input latch with valid, sticky overrun and CPU acknowledge
//  Revision     : 1.0
// ============================================================================
module mmio_in_chan (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_pulse,
   input  logic [31:0] i_data,
   input  logic        i_ack,
   output logic        o_valid,
   output logic        o_overrun,
   output logic [31:0] o_data
);

   logic        r_valid;
   logic        r_overrun;
   logic [31:0] r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_data    <= '0;
      end else if (i_ack) begin
         // Ack empties the latch first, so a coincident pulse lands cleanly.
         r_valid   <= i_pulse;
         r_overrun <= 1'b0;
         if (i_pulse)
            r_data <= i_data;
      end else if (i_pulse) begin
         if (r_valid) begin
            r_overrun <= 1'b1;
         end else begin
            r_valid <= 1'b1;
            r_data  <= i_data;
         end
      end
   end

   assign o_valid   = r_valid;
   assign o_overrun = r_overrun;
   assign o_data    = r_data;

endmodule
`default_nettype wire

// File: rtl/mem_mmio_bus.sv
`default_nettype none
// ============================================================================
//  mem_mmio_bus : CPU data-bus decoder for data memory and PDU MMIO registers
//  Revision     : 1.0
// ============================================================================
module mem_mmio_bus
   import mmio_pkg::*;
#(
   parameter int          DM_AW     = 8,
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
   parameter int          LED_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      mem_addr,
   input  logic             mem_we,
   input  logic [31:0]      mem_din,
   output logic [31:0]      mem_dout,
   output logic [DM_AW-1:0] dm_addr,
   output logic             dm_we,
   output logic [31:0]      dm_din,
   input  logic [31:0]      dm_dout,
   output logic             out_valid,
   output logic [31:0]      out_data,
   input  logic             out_ack,
   input  logic             in_pulse,
   input  logic [31:0]      in_data,
   output logic [LED_W-1:0] led
);

   logic [31:0]      w_off;
   logic             w_dm_hit;
   logic             w_mmio_hit;
   logic [2:0]       w_word;
   logic             w_mmio_we;
   logic             w_wr_odata;
   logic             w_wr_istat;
   logic             w_wr_cyc;
   logic             w_wr_led;
   logic             w_in_valid;
   logic             w_in_ovr;
   logic [31:0]      w_in_data;

   logic             r_out_valid;
   logic [31:0]      r_out_data;
   logic [31:0]      r_cycles;
   logic [LED_W-1:0] r_led;

   assign w_off      = mem_addr - MMIO_BASE;
   assign w_dm_hit   = (mem_addr >> (DM_AW + 2)) == 32'd0;
   // mem_addr >= base guarantees the subtraction did not wrap.
   assign w_mmio_hit = !w_dm_hit && (mem_addr >= MMIO_BASE) && (w_off < 32'(MMIO_WIN_BYTES));
   assign w_word     = w_off[4:2];
   assign w_mmio_we  = mem_we && w_mmio_hit;
   assign w_wr_odata = w_mmio_we && (w_word == OFF_OUT_DATA[4:2]);
   assign w_wr_istat = w_mmio_we && (w_word == OFF_IN_STAT[4:2]);
   assign w_wr_cyc   = w_mmio_we && (w_word == OFF_CYCLES[4:2]);
   assign w_wr_led   = w_mmio_we && (w_word == OFF_LED[4:2]);

   assign dm_addr = mem_addr[DM_AW+1:2];
   assign dm_we   = mem_we && w_dm_hit;
   assign dm_din  = mem_din;

   mmio_in_chan u_in_chan (
      .clk       (clk),
      .rst       (rst),
      .i_pulse   (in_pulse),
      .i_data    (in_data),
      .i_ack     (w_wr_istat),
      .o_valid   (w_in_valid),
      .o_overrun (w_in_ovr),
      .o_data    (w_in_data)
   );

   // Data is frozen while valid; an ack in the same cycle as a write wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (r_out_valid) begin
         if (out_ack)
            r_out_valid <= 1'b0;
      end else if (w_wr_odata) begin
         r_out_valid <= 1'b1;
         r_out_data  <= mem_din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_cycles <= '0;
      else if (w_wr_cyc)
         r_cycles <= mem_din;
      else
         r_cycles <= r_cycles + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_led <= '0;
      else if (w_wr_led)
         r_led <= mem_din[LED_W-1:0];
   end

   always_comb begin
      mem_dout = '0;
      if (w_dm_hit) begin
         mem_dout = dm_dout;
      end else if (w_mmio_hit) begin
         case (w_word)
            OFF_OUT_STAT[4:2]: mem_dout[OUT_STAT_RDY_BIT] = !r_out_valid;
            OFF_IN_STAT[4:2]: begin
               mem_dout[IN_STAT_VLD_BIT] = w_in_valid;
               mem_dout[IN_STAT_OVR_BIT] = w_in_ovr;
            end
            OFF_IN_DATA[4:2]:  mem_dout = w_in_data;
            OFF_CYCLES[4:2]:   mem_dout = r_cycles;
            OFF_LED[4:2]:      mem_dout = 32'(r_led);
            default:           mem_dout = '0;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign led       = r_led;

endmodule
`default_nettype wire

// File: tb/tb_mem_mmio_bus.sv
`default_nettype none
// ============================================================================
//  tb_mem_mmio_bus : directed stimulus with queued expectations for mem_mmio_bus
//  Revision        : 1.0
// ============================================================================
module tb_mem_mmio_bus;

   localparam int K_DOUT   = 0;
   localparam int K_OVALID = 1;
   localparam int K_ODATA  = 2;
   localparam int K_LED    = 3;
   localparam int K_DMWE   = 4;
   localparam int K_DMADDR = 5;
   localparam int K_DMDIN  = 6;

   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } chk_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic [7:0]  dm_addr;
   logic        dm_we;
   logic [31:0] dm_din;
   logic [31:0] dm_dout = 32'h600D_F00D;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ack;
   logic        in_pulse;
   logic [31:0] in_data;
   logic [15:0] led;

   chk_t q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mem_mmio_bus dut (
      .clk       (clk),
      .rst       (rst),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .dm_addr   (dm_addr),
      .dm_we     (dm_we),
      .dm_din    (dm_din),
      .dm_dout   (dm_dout),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ack   (out_ack),
      .in_pulse  (in_pulse),
      .in_data   (in_data),
      .led       (led)
   );

   function automatic logic [31:0] act_of(int k);
      case (k)
         K_DOUT:   return mem_dout;
         K_OVALID: return {31'd0, out_valid};
         K_ODATA:  return out_data;
         K_LED:    return {16'd0, led};
         K_DMWE:   return {31'd0, dm_we};
         K_DMADDR: return {24'd0, dm_addr};
         default:  return dm_din;
      endcase
   endfunction

   // Monitor: inputs settle 1 time unit after posedge, so negedge is a quiet sample point.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         chk_t c;
         logic [31:0] a;
         c = q.pop_front();
         a = act_of(c.kind);
         total++;
         if (a !== c.exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", c.name, a, c.exp);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input int k, input logic [31:0] e, input string n);
      chk_t c;
      c.kind = k;
      c.exp  = e;
      c.name = n;
      q.push_back(c);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
      mem_addr = a;
      mem_we   = 1'b0;
      chk(K_DOUT, e, n);
      step();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      mem_addr = a;
      mem_we   = 1'b1;
      mem_din  = d;
      step();
      mem_we   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; mem_addr = '0; mem_we = 1'b0; mem_din = '0;
      out_ack = 1'b0; in_pulse = 1'b0; in_data = '0;
      repeat (3) step();
      rst = 1'b0;

      // Reset values and counter running from 0
      chk(K_OVALID, 32'd0, "rst_out_valid");
      chk(K_LED, 32'd0, "rst_led");
      rd(32'h7f10, 32'd0, "cyc0");
      rd(32'h7f10, 32'd1, "cyc1");
      rd(32'h7f10, 32'd2, "cyc2");
      rd(32'h7f00, 32'd1, "rst_out_stat");
      rd(32'h7f08, 32'd0, "rst_in_stat");
      rd(32'h7f0c, 32'd0, "rst_in_data");
      rd(32'h7f04, 32'd0, "out_data_rd0");

      // Output channel
      wr(32'h7f04, 32'h1234_5678);
      chk(K_OVALID, 32'd1, "ovalid_set");
      chk(K_ODATA, 32'h1234_5678, "odata_set");
      rd(32'h7f00, 32'd0, "out_stat_busy");
      wr(32'h7f04, 32'h0000_DEAD);
      chk(K_ODATA, 32'h1234_5678, "odata_held");
      rd(32'h7f00, 32'd0, "out_stat_still_busy");
      out_ack = 1'b1;
      wr(32'h7f04, 32'h0000_BEEF);
      out_ack = 1'b0;
      chk(K_OVALID, 32'd0, "ack_clears");
      rd(32'h7f00, 32'd1, "out_stat_free");
      out_ack = 1'b1;
      step();
      out_ack = 1'b0;
      chk(K_OVALID, 32'd0, "ack_idle_ignored");
      wr(32'h7f04, 32'h0000_CAFE);
      chk(K_OVALID, 32'd1, "ovalid_reload");
      rd(32'h7f00, 32'd0, "out_stat_reload");
      chk(K_ODATA, 32'h0000_CAFE, "odata_reload");
      step();

      // Input channel
      in_data = 32'hA5; in_pulse = 1'b1;
      step();
      in_pulse = 1'b0;
      rd(32'h7f08, 32'd1, "in_stat_valid");
      rd(32'h7f0c, 32'hA5, "in_data_a5");
      in_data = 32'h5A; in_pulse = 1'b1;
      step();
      in_pulse = 1'b0;
      rd(32'h7f08, 32'd3, "in_stat_overrun");
      rd(32'h7f0c, 32'hA5, "in_data_kept");
      wr(32'h7f08, 32'd0);
      rd(32'h7f08, 32'd0, "in_stat_acked");

      // Ack and pulse together while valid+overrun
      in_data = 32'h11; in_pulse = 1'b1;
      step();
      in_data = 32'h22;
      step();
      in_pulse = 1'b0;
      rd(32'h7f08, 32'd3, "in_stat_pre");
      rd(32'h7f0c, 32'h11, "in_data_pre");
      mem_addr = 32'h7f08; mem_we = 1'b1; mem_din = 32'h0;
      in_data = 32'h77; in_pulse = 1'b1;
      step();
      mem_we = 1'b0; in_pulse = 1'b0;
      rd(32'h7f08, 32'd1, "in_stat_ack_pulse");
      rd(32'h7f0c, 32'h77, "in_data_ack_pulse");

      // Counter load/wrap and LED
      wr(32'h7f10, 32'hFFFF_FFFE);
      rd(32'h7f10, 32'hFFFF_FFFE, "cyc_loaded");
      rd(32'h7f10, 32'hFFFF_FFFF, "cyc_max");
      rd(32'h7f10, 32'h0000_0000, "cyc_wrap");
      wr(32'h7f14, 32'h0000_FFFF);
      chk(K_LED, 32'h0000_FFFF, "led_ffff");
      rd(32'h7f14, 32'h0000_FFFF, "led_rd_ffff");
      wr(32'h7f14, 32'hABCD_1234);
      chk(K_LED, 32'h0000_1234, "led_trunc");
      rd(32'h7f14, 32'h0000_1234, "led_rd_trunc");

      // Data memory and unmapped space
      mem_addr = 32'h10; mem_we = 1'b1; mem_din = 32'h9;
      chk(K_DMWE, 32'd1, "dm_we_hit");
      chk(K_DMADDR, 32'd4, "dm_addr_4");
      chk(K_DMDIN, 32'd9, "dm_din_9");
      step();
      mem_we = 1'b0;
      rd(32'h10, 32'h600D_F00D, "dm_read");
      mem_addr = 32'h5000; mem_we = 1'b1; mem_din = 32'h1;
      chk(K_DMWE, 32'd0, "dm_we_unmapped");
      step();
      mem_we = 1'b0;
      rd(32'h5000, 32'd0, "unmapped_rd");
      mem_addr = 32'h3fc;
      chk(K_DMADDR, 32'hFF, "dm_addr_top");
      rd(32'h3fc, 32'h600D_F00D, "dm_top_rd");
      rd(32'h400, 32'd0, "dm_above_rd");
      rd(32'h7f18, 32'd0, "mmio_undef_rd");
      rd(32'h7f20, 32'd0, "mmio_above_rd");
      rd(32'h7efc, 32'd0, "mmio_below_rd");

      // Reset wins over simultaneous write, pulse and pending handshakes
      rst = 1'b1;
      mem_addr = 32'h7f14; mem_we = 1'b1; mem_din = 32'h5555;
      in_data = 32'h99; in_pulse = 1'b1;
      step();
      rst = 1'b0; mem_we = 1'b0; in_pulse = 1'b0;
      chk(K_OVALID, 32'd0, "rst2_out_valid");
      chk(K_ODATA, 32'd0, "rst2_out_data");
      chk(K_LED, 32'd0, "rst2_led");
      rd(32'h7f10, 32'd0, "rst2_cycles");
      rd(32'h7f08, 32'd0, "rst2_in_stat");
      rd(32'h7f0c, 32'd0, "rst2_in_data");
      rd(32'h7f00, 32'd1, "rst2_out_stat");

      step();
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
